// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with next-PC selection, redirect holding and halt.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets halt the unit instead of being masked.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_target_q;
  logic        pend_valid_q;
  logic        pc_valid_q;
  logic        halted_q;
  logic        misalign_q;

  logic        adv;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        load_en;
  logic [31:0] load_target;
  logic        load_bad;

  assign pc_plus4    = pc_q + 32'd4;
  assign adv         = pc_valid_q & imem_ready & ~stall;
  assign redir_valid = jump_reg | jump | branch_taken;

  always_comb begin
    if (jump_reg) begin
      redir_target = jr_target;
    end else if (jump) begin
      redir_target = {pc_plus4[31:28], jump_index, 2'b00};
    end else begin
      redir_target = pc_plus4 + branch_offset;
    end
  end

  // A live redirect beats a held one; halt suppresses any load this cycle.
  always_comb begin
    load_en     = 1'b0;
    load_target = redir_target;
    if ((state_q == StRun) && !halt && adv) begin
      if (redir_valid) begin
        load_en = 1'b1;
      end else if (pend_valid_q) begin
        load_en     = 1'b1;
        load_target = pend_target_q;
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign load_bad = (load_target[1:0] != 2'b00);
`else
  assign load_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'd0;
      pend_valid_q  <= 1'b0;
      pc_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        StBoot: begin
          state_q    <= StRun;
          pc_valid_q <= 1'b1;
        end
        StRun: begin
          if (halt || (load_en && load_bad)) begin
            state_q      <= StHalt;
            pc_valid_q   <= 1'b0;
            halted_q     <= 1'b1;
            pend_valid_q <= 1'b0;
            if (load_en && load_bad) begin
              misalign_q <= 1'b1;
            end
          end else if (load_en) begin
            pc_q         <= load_target & 32'hFFFF_FFFC;
            pend_valid_q <= 1'b0;
          end else if (redir_valid) begin
            pend_target_q <= redir_target;
            pend_valid_q  <= 1'b1;
          end else if (adv) begin
            pc_q <= pc_plus4;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances (default and wrap-around RESET_PC)
// share stimulus; a behavioural model is compared every cycle, plus literal checkpoints.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic        halt;

  logic [31:0] pc0, pp0, pc1, pp1;
  logic        v0, h0, e0, v1, h1, e1;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  localparam logic [1:0] MBoot = 2'd0, MRun = 2'd1, MHalt = 2'd2;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] PcAfterMis = 32'h0040_0104;
  localparam logic [31:0] ErrAfterMis = 32'd1;
  localparam logic [31:0] HaltAfterMis = 32'd1;
`else
  localparam logic [31:0] PcAfterMis = 32'h0040_0100;
  localparam logic [31:0] ErrAfterMis = 32'd0;
  localparam logic [31:0] HaltAfterMis = 32'd0;
`endif

  pc_fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jump_reg(jump_reg), .jr_target(jr_target), .halt(halt),
    .pc(pc0), .pc_plus4(pp0), .pc_valid(v0), .halted(h0), .misalign_err(e0)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jump_reg(jump_reg), .jr_target(jr_target), .halt(halt),
    .pc(pc1), .pc_plus4(pp1), .pc_valid(v1), .halted(h1), .misalign_err(e1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] pc;
    logic        pv;
    logic [31:0] pt;
    logic        err;
  } model_t;

  model_t m [2];

  function automatic model_t step(input model_t s, input logic [31:0] rpc);
    model_t      n;
    logic [31:0] p4;
    logic        go;
    logic        req;
    logic        take;
    logic [31:0] tgt;
    logic [31:0] lt;
    n    = s;
    p4   = s.pc + 32'd4;
    go   = (s.mode == MRun) && imem_ready && !stall;
    req  = jump_reg || jump || branch_taken;
    take = 1'b0;
    lt   = 32'd0;
    if (jump_reg)  tgt = jr_target;
    else if (jump) tgt = {p4[31:28], jump_index, 2'b00};
    else           tgt = p4 + branch_offset;
    if (reset) begin
      n.mode = MBoot; n.pc = rpc; n.pv = 1'b0; n.pt = 32'd0; n.err = 1'b0;
    end else if (s.mode == MBoot) begin
      n.mode = MRun;
    end else if (s.mode == MRun) begin
      if (halt) begin
        n.mode = MHalt; n.pv = 1'b0;
      end else if (req && go) begin
        take = 1'b1; lt = tgt; n.pv = 1'b0;
      end else if (req) begin
        n.pv = 1'b1; n.pt = tgt;
      end else if (s.pv && go) begin
        take = 1'b1; lt = s.pt; n.pv = 1'b0;
      end else if (go) begin
        n.pc = p4;
      end
      if (take) begin
`ifdef PC_MISALIGN_TRAP_EN
        if (lt[1:0] != 2'b00) begin
          n.err = 1'b1; n.mode = MHalt; n.pv = 1'b0;
        end else begin
          n.pc = lt;
        end
`else
        n.pc = {lt[31:2], 2'b00};
`endif
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= step(m[0], 32'h0040_0000);
    m[1] <= step(m[1], 32'hFFFF_FFFC);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] p, input logic [31:0] pp,
                          input logic v, input logic h, input logic e);
    check($sformatf("model_pc[%0d]", i), p, m[i].pc);
    check($sformatf("model_pc_plus4[%0d]", i), pp, m[i].pc + 32'd4);
    check($sformatf("model_pc_valid[%0d]", i), {31'd0, v}, {31'd0, m[i].mode == MRun});
    check($sformatf("model_halted[%0d]", i), {31'd0, h}, {31'd0, m[i].mode == MHalt});
    check($sformatf("model_misalign[%0d]", i), {31'd0, e}, {31'd0, m[i].err});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, pc0, pp0, v0, h0, e0);
      cmp_inst(1, pc1, pp1, v1, h1, e1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_offset = 32'd0; jump = 1'b0; jump_index = 26'd0;
    jump_reg = 1'b0; jr_target = 32'd0;

    // 1: reset, boot cycle, sequential fetch
    cyc(); chk_en = 1'b1; cyc();
    reset = 1'b0;
    check("rst_pc", pc0, 32'h0040_0000);
    check("rst_valid", {31'd0, v0}, 32'd0);
    check("rst_wrap_pc", pc1, 32'hFFFF_FFFC);
    cyc();
    check("boot_pc", pc0, 32'h0040_0000);
    check("boot_valid", {31'd0, v0}, 32'd1);
    cyc();
    check("seq_pc4", pc0, 32'h0040_0004);
    check("wrap_pc0", pc1, 32'h0000_0000);
    cyc();
    check("seq_pc8", pc0, 32'h0040_0008);
    cyc(); cyc();
    check("seq_pc10", pc0, 32'h0040_0010);

    // 2: backward branch, then same branch under stall
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
    cyc();
    check("branch_back", pc0, 32'h0040_0004);
    clr_req();
    cyc(); cyc(); cyc();
    check("seq_pc10b", pc0, 32'h0040_0010);
    branch_taken = 1'b1; stall = 1'b1;
    cyc();
    check("stall_hold1", pc0, 32'h0040_0010);
    clr_req();
    cyc();
    check("stall_hold2", pc0, 32'h0040_0010);
    stall = 1'b0;
    cyc();
    check("pending_branch", pc0, 32'h0040_0004);

    // 3: priority jump_reg > jump > branch
    jump_reg = 1'b1; jr_target = 32'h1000_0000;
    cyc();
    check("jr_to_1000", pc0, 32'h1000_0000);
    clr_req();
    jump = 1'b1; jump_index = 26'h000_0100; branch_taken = 1'b1;
    cyc();
    check("jump_beats_branch", pc0, 32'h1000_0400);
    jump_reg = 1'b1; jr_target = 32'h0040_0200;
    cyc();
    check("jr_beats_all", pc0, 32'h0040_0200);
    clr_req();

    // 4: JR captured while imem not ready
    jump_reg = 1'b1; jr_target = 32'h0040_0100; imem_ready = 1'b0;
    cyc();
    check("nready_hold1", pc0, 32'h0040_0200);
    clr_req();
    cyc(); cyc();
    check("nready_hold3", pc0, 32'h0040_0200);
    imem_ready = 1'b1;
    cyc();
    check("pending_jr", pc0, 32'h0040_0100);
    cyc();
    check("after_pending_jr", pc0, 32'h0040_0104);

    // 6: misaligned JR target
    jump_reg = 1'b1; jr_target = 32'h0040_0102;
    cyc();
    clr_req();
    check("mis_pc", pc0, PcAfterMis);
    check("mis_err", {31'd0, e0}, ErrAfterMis);
    check("mis_halted", {31'd0, h0}, HaltAfterMis);

    // 5: halt freezes the unit; only reset leaves
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    check("halt_flag", {31'd0, h0}, 32'd1);
    check("halt_valid", {31'd0, v0}, 32'd0);
    jump_reg = 1'b1; jr_target = 32'h0000_0040;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("halt_frozen", pc0, PcAfterMis);
    end
    clr_req();
    reset = 1'b1;
    cyc();
    check("rst_from_halt_pc", pc1, 32'hFFFF_FFFC);
    check("rst_from_halt_flag", {31'd0, h1}, 32'd0);
    check("rst_from_halt_err", {31'd0, e0}, 32'd0);

    // halt during boot is ignored; reset discards a pending redirect
    reset = 1'b0; halt = 1'b1;
    cyc();
    halt = 1'b0;
    check("boot_halt_ignored", {31'd0, h0}, 32'd0);
    check("boot_halt_valid", {31'd0, v0}, 32'd1);
    stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h0050_0000;
    cyc();
    clr_req();
    reset = 1'b1;
    cyc();
    reset = 1'b0; stall = 1'b0;
    cyc(); cyc();
    check("pending_dropped_by_reset", pc0, 32'h0040_0004);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
